feature_map_stream_tx_layer6: RTL and testbench
===============================================

# feature_map_stream_tx_layer6

Transmitter end of the layer-6 pixel stream. Accepts one channel word at a time from an upstream feature-map buffer over a valid/ready handshake. Packs `CHANNELS` words into one full-width pixel and emits `IMG_WIDHT*IMG_HEIGHT` pixels in raster order on the same `Data`/`Valid` stream that the layer-6 separable convolution consumes. Sits between the feature-map buffer reader and the layer-6 `Data_In`/`Valid_In` inputs.

## Interface
Parameters:
- `DATA_WIDHT`, 32: bits per channel word.
- `CHANNELS`, 128: channel words per pixel.
- `IMG_WIDHT`, 44: pixels per row.
- `IMG_HEIGHT`, 44: rows per frame.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `Start`, input, 1: begin one frame; sampled only in IDLE.
- `Word_In`, input, DATA_WIDHT: channel word from upstream.
- `Word_Valid`, input, 1: `Word_In` is valid.
- `Word_Ready`, output, 1: block accepts `Word_In` this cycle.
- `Data_Out`, output, DATA_WIDHT*CHANNELS: packed pixel; channel c occupies bits [c*DATA_WIDHT +: DATA_WIDHT].
- `Valid_Out`, output, 1: one-cycle pulse when `Data_Out` holds a new pixel.
- `Busy`, output, 1: a frame is in progress.
- `Frame_Done`, output, 1: one-cycle pulse after the last pixel of the frame.

## Operation
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE
  - `Busy`=0, `Word_Ready`=0.
  - `Start`=1 moves to LOAD and clears `ch_cnt` and `pix_cnt`.
- LOAD
  - `Word_Ready`=1.
  - A word is accepted when `Word_Valid` && `Word_Ready`. The accepted word is written into assembly slot `ch_cnt`, then `ch_cnt` increments.
  - Accepting the word with `ch_cnt`==CHANNELS-1 copies the assembled pixel (including that word) into `Data_Out`, clears `ch_cnt` and moves to SEND.
  - `Word_Valid`=0 stalls indefinitely with no state change.
- SEND (exactly one cycle)
  - `Valid_Out`=1, `Word_Ready`=0.
  - If `pix_cnt`==IMG_WIDHT*IMG_HEIGHT-1, go to DONE.
  - Otherwise increment `pix_cnt` and go to LOAD.
- DONE (exactly one cycle)
  - `Frame_Done`=1, `Word_Ready`=0.
  - Next state is IDLE.
- `Busy`=1 in LOAD, SEND and DONE.
- `Start` outside IDLE is ignored and not queued.
- `Data_Out` changes only on the edge entering SEND. It holds the last pixel stable until the next pixel completes.
- Words offered while `Word_Ready`=0 are not consumed. Upstream holds them.
- Counter widths:
  - `ch_cnt` is $clog2(CHANNELS) bits.
  - `pix_cnt` is $clog2(IMG_WIDHT*IMG_HEIGHT) bits (11 bits at default).
  - Neither counter wraps except through the explicit clears above.
- Data is passed through bit-exact, with no arithmetic.

## Timing
- Reset values:
  - State IDLE, `ch_cnt`=0, `pix_cnt`=0.
  - `Data_Out`=0, `Valid_Out`=0, `Word_Ready`=0, `Busy`=0, `Frame_Done`=0.
- `rst` mid-frame:
  - Returns to IDLE on the next edge and discards the partial pixel.
  - Emits no `Valid_Out` or `Frame_Done` for the aborted frame.
  - `rst` takes priority over `Start` in the same cycle.
- `Start` high at edge t: `Word_Ready`=1 and `Busy`=1 from cycle t+1.
- Last word of a pixel accepted at edge k:
  - `Valid_Out`=1 with the new `Data_Out` during cycle k+1.
  - `Word_Ready`=0 during cycle k+1 and returns to 1 at k+2, unless the frame ends.
- Last pixel of the frame:
  - `Valid_Out` in cycle k+1, `Frame_Done` in cycle k+2.
  - IDLE (`Busy`=0) from cycle k+3.
  - A new `Start` is accepted from cycle k+3.
- With `Word_Valid` held high, each pixel takes CHANNELS+1 cycles.
- A full default frame takes 1936*129 cycles, plus 1 cycle for `Frame_Done`.
- `Valid_Out` is never high on two consecutive cycles.

## Test plan
- Reset/idle:
  - Stimulus: hold `rst` for 2 cycles, then drive `Word_Valid`=1 with no `Start`.
  - Required: all outputs 0; `Word_Ready` stays 0 and no words are consumed.
- Single pixel, with CHANNELS=4, IMG_WIDHT=IMG_HEIGHT=1:
  - Stimulus: `Start`, then words 0x11, 0x22, 0x33, 0x44 back-to-back.
  - Required: one `Valid_Out` with `Data_Out`=0x00000044_00000033_00000022_00000011, `Frame_Done` on the next cycle, `Busy` low one cycle later.
- Stalls, with CHANNELS=4, 2x2 image:
  - Stimulus: deassert `Word_Valid` randomly; words carry the global index 0..15.
  - Required: exactly 4 `Valid_Out` pulses in raster order; pixel p holds words 4p..4p+3; `Data_Out` stable between pulses.
- Start while busy:
  - Stimulus: pulse `Start` during LOAD and again in the DONE cycle.
  - Required: both pulses ignored; frame length unchanged; block ends in IDLE.
- Reset mid-pixel:
  - Stimulus: assert `rst` after 2 of 4 words.
  - Required: IDLE next cycle, no `Valid_Out`; a fresh `Start` then produces a correct first pixel from new words only.
- Default parameters, continuous `Word_Valid`:
  - Required: 1936 `Valid_Out` pulses spaced 129 cycles apart and one `Frame_Done`, 1 cycle after the last pulse.

Source files
------------

// File: rtl/feature_map_stream_tx_layer6.sv
// feature_map_stream_tx_layer6
//
// Transmitter end of the layer-6 pixel stream. Channel words arrive one at a
// time from the feature-map buffer reader. CHANNELS words are packed into one
// full-width pixel. IMG_WIDHT*IMG_HEIGHT pixels are emitted in raster order on
// the Data_Out/Valid_Out stream that feeds the layer-6 separable convolution.
//
// Handshake: a word transfers on a rising edge where Word_Valid && Word_Ready.
// Word_Ready does not depend on Word_Valid. Upstream must hold Word_In stable
// while Word_Valid is high and Word_Ready is low. Valid_Out is a one-cycle
// pulse with no back-pressure.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   Start      - begin one frame (sampled in IDLE only)
//   Word_In    - channel word from upstream
//   Word_Valid - Word_In is valid
//   Word_Ready - block accepts Word_In this cycle (high only in LOAD)
//   Data_Out   - packed pixel, channel c at [c*DATA_WIDHT +: DATA_WIDHT]
//   Valid_Out  - one-cycle pulse when Data_Out holds a new pixel
//   Busy       - a frame is in progress
//   Frame_Done - one-cycle pulse after the last pixel of the frame
//   state_dbg  - current FSM state (0 IDLE, 1 LOAD, 2 SEND, 3 DONE)
module feature_map_stream_tx_layer6 #(
    parameter int DATA_WIDHT = 32,
    parameter int CHANNELS   = 128,
    parameter int IMG_WIDHT  = 44,
    parameter int IMG_HEIGHT = 44
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           Start,
    input  logic [DATA_WIDHT-1:0]          Word_In,
    input  logic                           Word_Valid,
    output logic                           Word_Ready,
    output logic [DATA_WIDHT*CHANNELS-1:0] Data_Out,
    output logic                           Valid_Out,
    output logic                           Busy,
    output logic                           Frame_Done,
    output logic [1:0]                     state_dbg
);

    localparam int PIXELS = IMG_WIDHT * IMG_HEIGHT;
    // Keep counters at least one bit wide for degenerate parameter choices.
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PIX_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                         state;
    logic [CH_W-1:0]                ch_cnt;
    logic [PIX_W-1:0]               pix_cnt;
    logic [DATA_WIDHT*CHANNELS-1:0] asm_buf;
    logic [DATA_WIDHT*CHANNELS-1:0] asm_next;

    // Assembly buffer with the incoming word dropped into slot ch_cnt. On the
    // last word of a pixel this is the complete pixel copied to Data_Out.
    always_comb begin
        asm_next = asm_buf;
        asm_next[int'(ch_cnt)*DATA_WIDHT +: DATA_WIDHT] = Word_In;
    end

    assign state_dbg = state;

    // All outputs are registered and updated together with the state, so
    // each one matches the state it belongs to in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ch_cnt     <= '0;
            pix_cnt    <= '0;
            asm_buf    <= '0;
            Data_Out   <= '0;
            Valid_Out  <= 1'b0;
            Word_Ready <= 1'b0;
            Busy       <= 1'b0;
            Frame_Done <= 1'b0;
        end else begin
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        state      <= LOAD;
                        ch_cnt     <= '0;
                        pix_cnt    <= '0;
                        Word_Ready <= 1'b1;
                        Busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    // Word_Ready is high throughout LOAD, so Word_Valid alone
                    // marks a transfer here.
                    if (Word_Valid) begin
                        asm_buf <= asm_next;
                        if (ch_cnt == CH_LAST) begin
                            Data_Out   <= asm_next;
                            ch_cnt     <= '0;
                            state      <= SEND;
                            Valid_Out  <= 1'b1;
                            Word_Ready <= 1'b0;
                        end else begin
                            ch_cnt <= ch_cnt + 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (pix_cnt == PIX_LAST) begin
                        state      <= DONE;
                        Frame_Done <= 1'b1;
                    end else begin
                        pix_cnt    <= pix_cnt + 1'b1;
                        state      <= LOAD;
                        Word_Ready <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    Word_Ready <= 1'b0;
                    Busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_feature_map_stream_tx_layer6.sv
// Bench for feature_map_stream_tx_layer6. Three instances share clock and
// reset: a (4 channels, 1x1 image), b (4 channels, 2x2 image) and
// c (128 channels, 4x4 image). Inputs change on the falling edge and outputs
// are sampled on the falling edge, away from the active rising edge.
module tb_feature_map_stream_tx_layer6;

    localparam int DW   = 32;
    localparam int CH_S = 4;
    localparam int CH_L = 128;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- instance signals ----------------
    logic              a_start, a_word_valid, a_word_ready, a_valid_out, a_busy, a_frame_done;
    logic [DW-1:0]     a_word_in;
    logic [DW*CH_S-1:0] a_data_out;
    logic [1:0]        a_state;

    logic              b_start, b_word_valid, b_word_ready, b_valid_out, b_busy, b_frame_done;
    logic [DW-1:0]     b_word_in;
    logic [DW*CH_S-1:0] b_data_out;
    logic [1:0]        b_state;

    logic              c_start, c_word_valid, c_word_ready, c_valid_out, c_busy, c_frame_done;
    logic [DW-1:0]     c_word_in;
    logic [DW*CH_L-1:0] c_data_out;
    logic [1:0]        c_state;

    feature_map_stream_tx_layer6 #(.DATA_WIDHT(DW), .CHANNELS(CH_S), .IMG_WIDHT(1), .IMG_HEIGHT(1)) dut_a (
        .clk(clk), .rst(rst), .Start(a_start), .Word_In(a_word_in), .Word_Valid(a_word_valid),
        .Word_Ready(a_word_ready), .Data_Out(a_data_out), .Valid_Out(a_valid_out), .Busy(a_busy),
        .Frame_Done(a_frame_done), .state_dbg(a_state)
    );

    feature_map_stream_tx_layer6 #(.DATA_WIDHT(DW), .CHANNELS(CH_S), .IMG_WIDHT(2), .IMG_HEIGHT(2)) dut_b (
        .clk(clk), .rst(rst), .Start(b_start), .Word_In(b_word_in), .Word_Valid(b_word_valid),
        .Word_Ready(b_word_ready), .Data_Out(b_data_out), .Valid_Out(b_valid_out), .Busy(b_busy),
        .Frame_Done(b_frame_done), .state_dbg(b_state)
    );

    feature_map_stream_tx_layer6 #(.DATA_WIDHT(DW), .CHANNELS(CH_L), .IMG_WIDHT(4), .IMG_HEIGHT(4)) dut_c (
        .clk(clk), .rst(rst), .Start(c_start), .Word_In(c_word_in), .Word_Valid(c_word_valid),
        .Word_Ready(c_word_ready), .Data_Out(c_data_out), .Valid_Out(c_valid_out), .Busy(c_busy),
        .Frame_Done(c_frame_done), .state_dbg(c_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [DW*CH_S-1:0] exp_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- stimulus ----------------
    int idx, pulses, cyc, last_cyc, done_cyc, first_cyc;
    int stab_err, b2b, gap_err, data_err;
    logic rdy, prev_v, seen_done, mid_start_sent;
    logic [DW*CH_S-1:0] exp_pix, last_pix;
    logic [DW-1:0] a_words[4];

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_word_valid = 1'b0; a_word_in = '0;
        b_start = 1'b0; b_word_valid = 1'b0; b_word_in = '0;
        c_start = 1'b0; c_word_valid = 1'b0; c_word_in = '0;

        // ---- reset / idle ----
        @(negedge clk);
        @(negedge clk);
        check("rst_data",   128'(a_data_out),   128'(0));
        check("rst_valid",  128'(a_valid_out),  128'(0));
        check("rst_ready",  128'(a_word_ready), 128'(0));
        check("rst_busy",   128'(a_busy),       128'(0));
        check("rst_done",   128'(a_frame_done), 128'(0));
        check("rst_state",  128'(a_state),      128'(0));
        check("rst_busy_c", 128'(c_busy),       128'(0));
        rst = 1'b0;
        a_word_valid = 1'b1;
        a_word_in = 32'hdead_beef;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("idle_ready%0d", i), 128'(a_word_ready), 128'(0));
        end
        check("idle_busy",  128'(a_busy),      128'(0));
        check("idle_valid", 128'(a_valid_out), 128'(0));
        a_word_valid = 1'b0;

        // ---- single pixel, 1x1 image ----
        a_words[0] = 32'h11; a_words[1] = 32'h22; a_words[2] = 32'h33; a_words[3] = 32'h44;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check("single_start_ready", 128'(a_word_ready), 128'(1));
        check("single_start_busy",  128'(a_busy),       128'(1));
        a_word_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_word_in = a_words[i];
            @(negedge clk);
        end
        a_word_valid = 1'b0;
        check("single_valid", 128'(a_valid_out), 128'(1));
        check("single_data",  128'(a_data_out),  128'h00000044_00000033_00000022_00000011);
        check("single_ready_send", 128'(a_word_ready), 128'(0));
        check("single_done_early", 128'(a_frame_done), 128'(0));
        @(negedge clk);
        check("single_done",      128'(a_frame_done), 128'(1));
        check("single_valid_off", 128'(a_valid_out),  128'(0));
        check("single_busy_done", 128'(a_busy),       128'(1));
        @(negedge clk);
        check("single_busy_idle", 128'(a_busy),       128'(0));
        check("single_done_off",  128'(a_frame_done), 128'(0));
        check("single_data_hold", 128'(a_data_out),   128'h00000044_00000033_00000022_00000011);

        // ---- stalls, 2x2 image, with Start pulses while busy ----
        exp_q.delete();
        for (int p = 0; p < 4; p++)
            exp_q.push_back({32'(4*p+3), 32'(4*p+2), 32'(4*p+1), 32'(4*p)});
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        check("stall_start_ready", 128'(b_word_ready), 128'(1));
        idx = 0; rdy = 1'b0; pulses = 0; stab_err = 0; b2b = 0; prev_v = 1'b0;
        cyc = 0; seen_done = 1'b0; mid_start_sent = 1'b0; last_cyc = 0; done_cyc = 0;
        last_pix = '0;
        while (!seen_done && cyc < 400) begin
            if (b_word_valid && rdy) idx++;
            if (b_valid_out) begin
                if (exp_q.size() == 0) begin
                    check("stall_extra_pulse", 128'(pulses), 128'(4));
                end else begin
                    exp_pix = exp_q.pop_front();
                    check($sformatf("stall_pix%0d", pulses), 128'(b_data_out), 128'(exp_pix));
                end
                if (prev_v) b2b++;
                pulses++;
                last_pix = b_data_out;
                last_cyc = cyc;
            end else if (pulses > 0 && b_data_out !== last_pix) begin
                stab_err++;
            end
            prev_v = b_valid_out;
            if (b_frame_done) begin
                seen_done = 1'b1;
                done_cyc = cyc;
            end
            // one Start pulse while loading the second pixel
            b_start = 1'b0;
            if (!mid_start_sent && pulses == 1 && b_word_ready) begin
                b_start = 1'b1;
                mid_start_sent = 1'b1;
            end
            if (idx < 16) begin
                b_word_valid = ($urandom_range(0, 3) != 0);
                b_word_in = 32'(idx);
            end else begin
                b_word_valid = 1'b0;
            end
            rdy = b_word_ready;
            if (!seen_done) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("stall_done_seen",  128'(seen_done), 128'(1));
        check("stall_pulses",     128'(pulses),    128'(4));
        check("stall_consumed",   128'(idx),       128'(16));
        check("stall_queue_left", 128'(exp_q.size()), 128'(0));
        check("stall_stable",     128'(stab_err),  128'(0));
        check("stall_back2back",  128'(b2b),       128'(0));
        check("stall_mid_start",  128'(mid_start_sent), 128'(1));
        check("stall_done_gap",   128'(done_cyc - last_cyc), 128'(1));
        // Start pulse during the DONE cycle must not start another frame
        b_start = 1'b1;
        b_word_valid = 1'b0;
        @(negedge clk);
        b_start = 1'b0;
        check("stall_end_busy",  128'(b_busy),  128'(0));
        check("stall_end_state", 128'(b_state), 128'(0));
        @(negedge clk);
        check("stall_end_busy2",  128'(b_busy),       128'(0));
        check("stall_end_ready2", 128'(b_word_ready), 128'(0));

        // ---- reset mid-pixel ----
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        b_word_valid = 1'b1;
        b_word_in = 32'ha0;
        @(negedge clk);
        b_word_in = 32'ha1;
        @(negedge clk);
        b_word_valid = 1'b0;
        rst = 1'b1;
        b_start = 1'b1;          // reset wins over Start in the same cycle
        @(negedge clk);
        rst = 1'b0;
        b_start = 1'b0;
        check("abort_busy",  128'(b_busy),       128'(0));
        check("abort_state", 128'(b_state),      128'(0));
        check("abort_valid", 128'(b_valid_out),  128'(0));
        check("abort_ready", 128'(b_word_ready), 128'(0));
        @(negedge clk);
        check("abort_busy2", 128'(b_busy),       128'(0));
        check("abort_valid2", 128'(b_valid_out), 128'(0));
        check("abort_fdone", 128'(b_frame_done), 128'(0));
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        b_word_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_word_in = 32'hb0 + 32'(i);
            @(negedge clk);
        end
        b_word_valid = 1'b0;
        check("abort_new_valid", 128'(b_valid_out), 128'(1));
        check("abort_new_data",  128'(b_data_out),  128'h000000b3_000000b2_000000b1_000000b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // ---- 128 channels, 4x4 image, continuous Word_Valid ----
        c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
        idx = 0; rdy = 1'b0; pulses = 0; cyc = 0; seen_done = 1'b0;
        gap_err = 0; data_err = 0; b2b = 0; prev_v = 1'b0;
        last_cyc = 0; done_cyc = 0; first_cyc = -1;
        c_word_valid = 1'b1;
        while (!seen_done && cyc < 3000) begin
            if (c_word_valid && rdy) idx++;
            if (c_valid_out) begin
                if (pulses == 0) first_cyc = cyc;
                else if (cyc - last_cyc != 129) gap_err++;
                if (c_data_out[DW-1:0] !== 32'(pulses*128) ||
                    c_data_out[127*DW +: DW] !== 32'(pulses*128 + 127) ||
                    c_data_out[64*DW +: DW] !== 32'(pulses*128 + 64))
                    data_err++;
                if (prev_v) b2b++;
                last_cyc = cyc;
                pulses++;
            end
            prev_v = c_valid_out;
            if (c_frame_done) begin
                seen_done = 1'b1;
                done_cyc = cyc;
            end
            c_word_in = 32'(idx);
            rdy = c_word_ready;
            if (!seen_done) begin
                @(negedge clk);
                cyc++;
            end
        end
        c_word_valid = 1'b0;
        check("wide_done_seen", 128'(seen_done), 128'(1));
        check("wide_first",     128'(first_cyc), 128'(128));
        check("wide_pulses",    128'(pulses),    128'(16));
        check("wide_gap",       128'(gap_err),   128'(0));
        check("wide_data",      128'(data_err),  128'(0));
        check("wide_back2back", 128'(b2b),       128'(0));
        check("wide_consumed",  128'(idx),       128'(16*128));
        check("wide_done_gap",  128'(done_cyc - last_cyc), 128'(1));
        @(negedge clk);
        check("wide_end_busy",  128'(c_busy),    128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
